md_unit: RTL

- Execute-stage multiply/divide unit for the pipelined MIPS core; owns the HI/LO registers.
- Consumes instructions the classifier flags as mcalc (mult, multu, div, divu, madd), mt (mthi, mtlo) and mf (mfhi, mflo).
- Models multi-cycle latency with a busy counter; the hazard unit uses `busy` to stall md-class instructions in decode.

---
 rtl/md_unit_if.sv | 22 ++
 rtl/md_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage request bus and HI/LO/busy status for the md unit.
// The pipeline side is the master; the md unit is the slave.
interface md_unit_if;
    logic [2:0]  md_op;
    logic        start;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_op, start, rs_val, rt_val, md_cancel,
        input  busy, hi, lo
    );

    modport slave (
        input  md_op, start, rs_val, rt_val, md_cancel,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit owning HI/LO.
// Multi-cycle latency is modelled with a busy countdown.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic      clk,
    input logic      reset_n,
    md_unit_if.slave md
);
    localparam int MAXN = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW = (MAXN > 1) ? $clog2(MAXN) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_e;
    typedef enum logic [2:0] {
        OP_NONE, OP_MULT, OP_MULTU, OP_DIV,
        OP_DIVU, OP_MADD, OP_MTHI, OP_MTLO
    } md_op_e;

    state_e      state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    md_op_e      op_q, op_n;
    logic [31:0] a_q, a_n, b_q, b_n;
    logic [31:0] hi_q, hi_n, lo_q, lo_n;

    logic [63:0] prod_s, prod_u, acc;
    logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag;
    logic [31:0] q_s, r_s, b_safe, q_u, r_u;
    logic        b_zero;
    logic        req, go_calc, go_mthi, go_mtlo, is_div;

    // Datapath from latched operands; HI/LO read live for madd.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        acc    = {hi_q, lo_q} + prod_s;
        b_zero = (b_q == 32'd0);
        a_mag  = a_q[31] ? -a_q : a_q;
        b_mag  = b_q[31] ? -b_q : b_q;
        b_div  = b_zero ? 32'd1 : b_mag;
        b_safe = b_zero ? 32'd1 : b_q;
        q_mag  = a_mag / b_div;
        r_mag  = a_mag % b_div;
        q_s    = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
        r_s    = a_q[31] ? -r_mag : r_mag;
        q_u    = a_q / b_safe;
        r_u    = a_q % b_safe;
    end

    always_comb begin
        req     = md.start && !md.md_cancel && (state_q == S_IDLE);
        go_calc = req && (md.md_op >= 3'd1) && (md.md_op <= 3'd5);
        go_mthi = req && (md.md_op == 3'd6);
        go_mtlo = req && (md.md_op == 3'd7);
        is_div  = (md.md_op == 3'd3) || (md.md_op == 3'd4);
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                unique case (1'b1)
                    go_calc: begin
                        state_n = S_RUN;
                        op_n    = md_op_e'(md.md_op);
                        a_n     = md.rs_val;
                        b_n     = md.rt_val;
                        cnt_n   = is_div ? CW'(DIV_CYCLES - 1)
                                         : CW'(MULT_CYCLES - 1);
                    end
                    go_mthi: hi_n = md.rs_val;
                    go_mtlo: lo_n = md.rs_val;
                    default: ;
                endcase
            end
            S_RUN: begin
                if (md.md_cancel) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (cnt_q == '0) begin
                    state_n = S_IDLE;
                    unique case (op_q)
                        OP_MULT:  {hi_n, lo_n} = prod_s;
                        OP_MULTU: {hi_n, lo_n} = prod_u;
                        OP_MADD:  {hi_n, lo_n} = acc;
                        OP_DIV: begin
                            if (!b_zero) begin
                                hi_n = r_s;
                                lo_n = q_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!b_zero) begin
                                hi_n = r_u;
                                lo_n = q_u;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            op_q    <= op_n;
            a_q     <= a_n;
            b_q     <= b_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
        end
    end

    assign md.busy = (state_q == S_RUN);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule
